regfile_wb_arbiter: RTL

//  Shares the single register-file write port between two writeback requesters: ALU/execute and load/store unit (LSU).

---
 rtl/regfile_wb_arbiter_if.sv | 43 ++++
 rtl/regfile_wb_arbiter.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback/regfile bus between the ALU and LSU requesters, the register file
// and decode. The arbiter uses the slave modport.
interface regfile_wb_arbiter_if #(
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DATA_W = 32
);
    logic              alu_valid;
    logic              alu_ready;
    logic [ADDR_W-1:0] alu_addr;
    logic [DATA_W-1:0] alu_data;
    logic              lsu_valid;
    logic              lsu_ready;
    logic [ADDR_W-1:0] lsu_addr;
    logic [DATA_W-1:0] lsu_data;
    logic              rf_we;
    logic [ADDR_W-1:0] rf_write_addr;
    logic [DATA_W-1:0] rf_din;
    logic [31:0]       pend_mask;
    logic [ADDR_W-1:0] rd_addr0;
    logic [ADDR_W-1:0] rd_addr1;
    logic [DATA_W-1:0] rf_dout0;
    logic [DATA_W-1:0] rf_dout1;
    logic [DATA_W-1:0] rd_data0;
    logic [DATA_W-1:0] rd_data1;

    modport master (
        output alu_valid, alu_addr, alu_data,
        output lsu_valid, lsu_addr, lsu_data,
        output rd_addr0, rd_addr1, rf_dout0, rf_dout1,
        input  alu_ready, lsu_ready,
        input  rf_we, rf_write_addr, rf_din, pend_mask,
        input  rd_data0, rd_data1
    );

    modport slave (
        input  alu_valid, alu_addr, alu_data,
        input  lsu_valid, lsu_addr, lsu_data,
        input  rd_addr0, rd_addr1, rf_dout0, rf_dout1,
        output alu_ready, lsu_ready,
        output rf_we, rf_write_addr, rf_din, pend_mask,
        output rd_data0, rd_data1
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares the single register-file write port between the
// ALU and LSU writeback requesters. Each requester has a 1-entry buffer; the
// winner is copied into a registered write stage. Also exports a pending-write
// mask for decode hazard checks.
// Optional feature macro: RF_BYPASS_EN forwards the in-flight write onto the
// two read ports; without it the read data is a plain passthrough.
module regfile_wb_arbiter #(
    parameter int unsigned ADDR_W       = 5,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned STARVE_LIMIT = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    regfile_wb_arbiter_if.slave bus
);
    localparam int unsigned MASK_W = 32;
    localparam int unsigned CNT_W  = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

    typedef struct packed {
        logic              v;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

    wb_entry_t         alu_q, alu_nxt;
    wb_entry_t         lsu_q, lsu_nxt;
    wb_entry_t         out_q, out_nxt;
    logic [CNT_W-1:0]  starve_q, starve_nxt;
    logic              alu_older_q, alu_older_nxt;
    logic [MASK_W-1:0] pend_q, pend_nxt;
    logic              grant_alu, grant_lsu;
    logic              alu_load, lsu_load;
    logic              same_dest, starved;

    // One-hot destination of a valid entry; x0 never shows up as pending
    function automatic logic [MASK_W-1:0] dest_bit(input wb_entry_t e);
        dest_bit = '0;
        if (e.v && (e.addr != '0)) begin
            dest_bit = MASK_W'(1) << e.addr;
        end
    endfunction

    assign same_dest = alu_q.v && lsu_q.v && (alu_q.addr == lsu_q.addr) && (alu_q.addr != '0);
    assign starved   = (starve_q == CNT_W'(STARVE_LIMIT));

    // Arbitration: ordering hazard first, then starvation override, then LSU priority
    always_comb begin
        grant_alu = 1'b0;
        grant_lsu = 1'b0;
        if (same_dest) begin
            if (alu_older_q) grant_alu = 1'b1;
            else             grant_lsu = 1'b1;
        end else if (alu_q.v && starved) begin
            grant_alu = 1'b1;
        end else if (lsu_q.v) begin
            grant_lsu = 1'b1;
        end else if (alu_q.v) begin
            grant_alu = 1'b1;
        end
    end

    // A buffer accepts when empty or draining in the same cycle
    assign bus.alu_ready = ~alu_q.v | grant_alu;
    assign bus.lsu_ready = ~lsu_q.v | grant_lsu;
    assign alu_load      = bus.alu_valid & bus.alu_ready;
    assign lsu_load      = bus.lsu_valid & bus.lsu_ready;

    // Next-state for buffers, write stage, starvation counter, age flag and mask
    always_comb begin
        alu_nxt       = alu_q;
        lsu_nxt       = lsu_q;
        out_nxt       = out_q;
        starve_nxt    = starve_q;
        alu_older_nxt = alu_older_q;

        if (grant_alu) alu_nxt.v = 1'b0;
        if (alu_load)  alu_nxt   = '{v: 1'b1, addr: bus.alu_addr, data: bus.alu_data};
        if (grant_lsu) lsu_nxt.v = 1'b0;
        if (lsu_load)  lsu_nxt   = '{v: 1'b1, addr: bus.lsu_addr, data: bus.lsu_data};

        // x0 writes are consumed here without raising the write enable
        out_nxt.v = 1'b0;
        if (grant_alu) begin
            out_nxt = '{v: (alu_q.addr != '0), addr: alu_q.addr, data: alu_q.data};
        end else if (grant_lsu) begin
            out_nxt = '{v: (lsu_q.addr != '0), addr: lsu_q.addr, data: lsu_q.data};
        end

        if (!alu_q.v || grant_alu) begin
            starve_nxt = '0;
        end else if (!starved) begin
            starve_nxt = starve_q + CNT_W'(1);
        end

        // Set when an LSU entry lands behind an ALU entry that is still waiting
        if (lsu_load && alu_q.v && !grant_alu) begin
            alu_older_nxt = 1'b1;
        end else if (grant_alu || !alu_q.v) begin
            alu_older_nxt = 1'b0;
        end

        pend_nxt = dest_bit(alu_nxt) | dest_bit(lsu_nxt) | dest_bit(out_nxt);
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_q       <= '0;
            lsu_q       <= '0;
            out_q       <= '0;
            starve_q    <= '0;
            alu_older_q <= 1'b0;
            pend_q      <= '0;
        end else begin
            alu_q       <= alu_nxt;
            lsu_q       <= lsu_nxt;
            out_q       <= out_nxt;
            starve_q    <= starve_nxt;
            alu_older_q <= alu_older_nxt;
            pend_q      <= pend_nxt;
        end
    end

    assign bus.rf_we         = out_q.v;
    assign bus.rf_write_addr = out_q.addr;
    assign bus.rf_din        = out_q.data;
    assign bus.pend_mask     = pend_q;

`ifdef RF_BYPASS_EN
    // Forward the write being committed this cycle; x0 reads are never forwarded
    assign bus.rd_data0 = (out_q.v && (out_q.addr == bus.rd_addr0) && (bus.rd_addr0 != '0))
                          ? out_q.data : bus.rf_dout0;
    assign bus.rd_data1 = (out_q.v && (out_q.addr == bus.rd_addr1) && (bus.rd_addr1 != '0))
                          ? out_q.data : bus.rf_dout1;
`else
    // Plain passthrough of the raw regfile read data
    logic unused_rd_addr;
    assign unused_rd_addr = ^{bus.rd_addr0, bus.rd_addr1};
    assign bus.rd_data0   = bus.rf_dout0;
    assign bus.rd_data1   = bus.rf_dout1;
`endif

endmodule
